// File: rtl/uart_rx_sampler.sv
// UART receiver driven by a 16x oversample tick: start-edge detect, mid-bit
// sampling of each data bit, stop-bit check and single-cycle byte/error strobes.
module uart_rx_sampler #(
    parameter int unsigned no_of_sample = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 baud_en,
    output logic                 rx_active,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err
);

    localparam int unsigned TICK_W = $clog2(no_of_sample);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(no_of_sample / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(no_of_sample - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_s, rx_d;
    logic                 armed, armed_n;
    logic [TICK_W-1:0]    tick_cnt, tick_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 active_n, valid_n, ferr_n;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_active <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            armed     <= armed_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            shift     <= shift_n;
            rx_active <= active_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        armed_n  = armed;
        tick_n   = tick_cnt;
        bit_n    = bit_cnt;
        shift_n  = shift;
        active_n = rx_active;
        data_n   = rx_data;
        valid_n  = 1'b0;
        ferr_n   = 1'b0;

        case (state)
            IDLE: begin
                active_n = 1'b0;
                if (rx_s) begin
                    armed_n = 1'b1;
                end
                // armed blocks restarts while the line is still held low after a break
                if (armed && rx_d && !rx_s) begin
                    state_n  = START;
                    active_n = 1'b1;
                    tick_n   = '0;
                end
            end

            START: begin
                if (baud_en) begin
                    if (tick_cnt == TICK_HALF) begin
                        tick_n = '0;
                        if (rx_s) begin
                            state_n  = IDLE;
                            active_n = 1'b0;
                        end else begin
                            state_n = DATA;
                            bit_n   = '0;
                        end
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
            end

            DATA: begin
                if (baud_en) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        shift_n = {rx_s, shift[DATA_BITS-1:1]};
                        bit_n   = bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state_n = STOP;
                        end
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
            end

            STOP: begin
                if (baud_en) begin
                    if (tick_cnt == TICK_LAST) begin
                        // Leave at mid-stop-bit so an immediately following start edge is seen
                        state_n  = IDLE;
                        active_n = 1'b0;
                        tick_n   = '0;
                        bit_n    = '0;
                        if (rx_s) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                        end else begin
                            ferr_n  = 1'b1;
                            armed_n = 1'b0;
                        end
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
            end

            default: begin
                state_n  = IDLE;
                active_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: table of frames plus hand-written
// sequences for false start, back-to-back frames, mid-frame reset and break.
module tb_uart_rx_sampler;

    localparam int unsigned NS      = 16;
    localparam int unsigned DB      = 8;
    localparam int unsigned DIV     = 5;
    localparam int unsigned BIT_CLK = NS * DIV;
    localparam int          BUDGET  = 4 * BIT_CLK;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          rx        = 1'b1;
    logic          baud_en   = 1'b0;
    logic          rx_active;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;

    uart_rx_sampler #(.no_of_sample(NS), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .baud_en   (baud_en),
        .rx_active (rx_active),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Baud generator model: counter held at 0 while rx_active is low
    int unsigned gen_cnt = 0;
    always @(posedge clk) begin
        if (!rx_active) begin
            gen_cnt <= 0;
            baud_en <= 1'b0;
        end else if (gen_cnt == DIV - 1) begin
            gen_cnt <= 0;
            baud_en <= 1'b1;
        end else begin
            gen_cnt <= gen_cnt + 1;
            baud_en <= 1'b0;
        end
    end

    // Output monitor
    int            n_valid = 0, n_ferr = 0, n_ticks = 0, n_both = 0, n_act_at_valid = 0;
    logic [DB-1:0] got_q[$];
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            got_q.push_back(rx_data);
            if (rx_active) n_act_at_valid++;
        end
        if (frame_err) n_ferr++;
        if (rx_valid && frame_err) n_both++;
        if (baud_en) n_ticks++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) rx = b;
        repeat (BIT_CLK - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < int'(DB); i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        @(negedge clk) rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_inactive(input string name);
        int k = 0;
        while (rx_active && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(rx_active), 0);
    endtask

    typedef struct {
        logic [DB-1:0] data;
        logic          stop;
        logic [DB-1:0] exp_data;
        int            exp_valid;
        int            exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int v0, f0, t0, q0, d0, d1;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_valid: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_data: 8'hA5, exp_valid: 0, exp_ferr: 1};
        vecs[2] = '{data: 8'h0F, stop: 1'b1, exp_data: 8'h0F, exp_valid: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'h80, stop: 1'b1, exp_data: 8'h80, exp_valid: 1, exp_ferr: 0};
        vecs[4] = '{data: 8'h01, stop: 1'b1, exp_data: 8'h01, exp_valid: 1, exp_ferr: 0};

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_active", int'(rx_active), 0);
        check("reset_rx_data",   int'(rx_data),   0);
        check("reset_rx_valid",  int'(rx_valid),  0);
        check("reset_frame_err", int'(frame_err), 0);
        rst = 1'b0;
        idle(2 * BIT_CLK);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            v0 = n_valid;
            f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].stop);
            idle(BIT_CLK);
            wait_inactive($sformatf("vec%0d_active_timeout", i));
            check($sformatf("vec%0d_valid_count", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr_count", i),  n_ferr - f0,  vecs[i].exp_ferr);
            check($sformatf("vec%0d_rx_data", i),     int'(rx_data), int'(vecs[i].exp_data));
        end

        // False start: low for 3 tick periods, abandoned on the 8th tick
        v0 = n_valid;
        f0 = n_ferr;
        t0 = n_ticks;
        @(negedge clk) rx = 1'b0;
        repeat (3 * DIV - 1) @(negedge clk);
        check("fs_active_rose", int'(rx_active), 1);
        rx = 1'b1;
        wait_inactive("fs_active_timeout");
        repeat (2 * DIV) @(negedge clk);
        check("fs_tick_count",   n_ticks - t0, 8);
        check("fs_valid_count",  n_valid - v0, 0);
        check("fs_ferr_count",   n_ferr - f0,  0);
        check("fs_rx_data",      int'(rx_data), 8'h01);
        idle(BIT_CLK);

        // Back-to-back frames with no idle gap
        q0 = got_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(BIT_CLK);
        wait_inactive("b2b_active_timeout");
        d0 = (got_q.size() > q0)     ? int'(got_q[q0])     : -1;
        d1 = (got_q.size() > q0 + 1) ? int'(got_q[q0 + 1]) : -1;
        check("b2b_valid_count", got_q.size() - q0, 2);
        check("b2b_first_byte",  d0, 8'h00);
        check("b2b_second_byte", d1, 8'hFF);
        check("b2b_rx_data",     int'(rx_data), 8'hFF);

        // Reset asserted in the middle of data bit 4
        v0 = n_valid;
        f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk) rx = 1'b0;
        repeat (BIT_CLK / 2) @(negedge clk);
        check("pre_rst_active", int'(rx_active), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_rx_active", int'(rx_active), 0);
        check("mid_rst_rx_data",   int'(rx_data),   0);
        check("mid_rst_rx_valid",  int'(rx_valid),  0);
        check("mid_rst_frame_err", int'(frame_err), 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle(2 * BIT_CLK);
        check("rst_no_valid", n_valid - v0, 0);
        check("rst_no_ferr",  n_ferr - f0,  0);
        send_frame(8'h5A, 1'b1);
        idle(BIT_CLK);
        wait_inactive("post_rst_active_timeout");
        check("post_rst_valid_count", n_valid - v0, 1);
        check("post_rst_rx_data",     int'(rx_data), 8'h5A);

        // Break: line low for 20 bit times, then recovery
        v0 = n_valid;
        f0 = n_ferr;
        @(negedge clk) rx = 1'b0;
        repeat (20 * BIT_CLK) @(negedge clk);
        check("brk_ferr_count",  n_ferr - f0,  1);
        check("brk_valid_count", n_valid - v0, 0);
        check("brk_rx_active",   int'(rx_active), 0);
        check("brk_rx_data",     int'(rx_data), 8'h5A);
        idle(2 * BIT_CLK);
        send_frame(8'h81, 1'b1);
        idle(BIT_CLK);
        wait_inactive("brk_rec_active_timeout");
        check("brk_rec_valid_count", n_valid - v0, 1);
        check("brk_rec_ferr_count",  n_ferr - f0,  1);
        check("brk_rec_rx_data",     int'(rx_data), 8'h81);

        // Global strobe properties
        check("valid_and_ferr_together", n_both, 0);
        check("active_high_at_valid",    n_act_at_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
